// File: rtl/axi4_arbiter_2to1.sv
// axi4_arbiter_2to1: two AXI4 masters share one slave port, one burst outstanding at a time.
// Optional build macro AXI_ARB_FIXED_PRIO_EN: master 0 always wins ties instead of round-robin.
`default_nettype none

module axi4_arbiter_2to1 #(
   parameter int A_WIDTH    = 32,
   parameter int BYTE_WIDTH = 2
) (
   input  logic                      clk,
   input  logic                      rstn,
   // master 0
   input  logic                      m0_awvalid,
   output logic                      m0_awready,
   input  logic [A_WIDTH-1:0]        m0_awaddr,
   input  logic [7:0]                m0_awlen,
   input  logic                      m0_wvalid,
   output logic                      m0_wready,
   input  logic                      m0_wlast,
   input  logic [8*BYTE_WIDTH-1:0]   m0_wdata,
   output logic                      m0_bvalid,
   input  logic                      m0_bready,
   input  logic                      m0_arvalid,
   output logic                      m0_arready,
   input  logic [A_WIDTH-1:0]        m0_araddr,
   input  logic [7:0]                m0_arlen,
   output logic                      m0_rvalid,
   input  logic                      m0_rready,
   output logic                      m0_rlast,
   output logic [8*BYTE_WIDTH-1:0]   m0_rdata,
   // master 1
   input  logic                      m1_awvalid,
   output logic                      m1_awready,
   input  logic [A_WIDTH-1:0]        m1_awaddr,
   input  logic [7:0]                m1_awlen,
   input  logic                      m1_wvalid,
   output logic                      m1_wready,
   input  logic                      m1_wlast,
   input  logic [8*BYTE_WIDTH-1:0]   m1_wdata,
   output logic                      m1_bvalid,
   input  logic                      m1_bready,
   input  logic                      m1_arvalid,
   output logic                      m1_arready,
   input  logic [A_WIDTH-1:0]        m1_araddr,
   input  logic [7:0]                m1_arlen,
   output logic                      m1_rvalid,
   input  logic                      m1_rready,
   output logic                      m1_rlast,
   output logic [8*BYTE_WIDTH-1:0]   m1_rdata,
   // slave
   output logic                      s_awvalid,
   input  logic                      s_awready,
   output logic [A_WIDTH-1:0]        s_awaddr,
   output logic [7:0]                s_awlen,
   output logic                      s_wvalid,
   input  logic                      s_wready,
   output logic                      s_wlast,
   output logic [8*BYTE_WIDTH-1:0]   s_wdata,
   input  logic                      s_bvalid,
   output logic                      s_bready,
   output logic                      s_arvalid,
   input  logic                      s_arready,
   output logic [A_WIDTH-1:0]        s_araddr,
   output logic [7:0]                s_arlen,
   input  logic                      s_rvalid,
   output logic                      s_rready,
   input  logic                      s_rlast,
   input  logic [8*BYTE_WIDTH-1:0]   s_rdata,
   output logic [1:0]                o_grant,
   output logic                      o_busy
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AW   = 3'd1,
      S_W    = 3'd2,
      S_B    = 3'd3,
      S_AR   = 3'd4,
      S_R    = 3'd5
   } state_t;

   state_t     r_state;
   logic [1:0] r_grant;
   logic       r_busy;
   logic       r_rr_last;
   logic [8:0] r_beat;
   logic [7:0] r_len;

   logic w_req0, w_req1, w_win, w_win_aw, w_sel;
   logic w_in_aw, w_in_b, w_in_ar, w_in_r, w_w_ok, w_last_beat;
   logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
   logic w_awready, w_wready, w_bvalid, w_arready, w_rvalid, w_rlast;

   assign w_req0 = m0_awvalid | m0_arvalid;
   assign w_req1 = m1_awvalid | m1_arvalid;

   always_comb begin
      w_win = w_req1 & ~w_req0;
      if (w_req0 & w_req1) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
         w_win = 1'b0;
`else
         w_win = ~r_rr_last;
`endif
      end
   end

   assign w_win_aw = w_win ? m1_awvalid : m0_awvalid;

   // Grant is cleared in S_IDLE, so outside a burst the mux points at master 0 but every valid/ready is gated off.
   assign w_sel       = r_grant[1];
   assign w_in_aw     = (r_state == S_AW);
   assign w_in_b      = (r_state == S_B);
   assign w_in_ar     = (r_state == S_AR);
   assign w_in_r      = (r_state == S_R);
   assign w_w_ok      = (r_state == S_W) && (r_beat <= {1'b0, r_len});
   assign w_last_beat = (r_beat == {1'b0, r_len});

   assign s_awvalid = w_in_aw & (w_sel ? m1_awvalid : m0_awvalid);
   assign s_awaddr  = w_sel ? m1_awaddr : m0_awaddr;
   assign s_awlen   = w_sel ? m1_awlen  : m0_awlen;
   assign s_wvalid  = w_w_ok & (w_sel ? m1_wvalid : m0_wvalid);
   assign s_wlast   = w_sel ? m1_wlast : m0_wlast;
   assign s_wdata   = w_sel ? m1_wdata : m0_wdata;
   assign s_bready  = w_in_b & (w_sel ? m1_bready : m0_bready);
   assign s_arvalid = w_in_ar & (w_sel ? m1_arvalid : m0_arvalid);
   assign s_araddr  = w_sel ? m1_araddr : m0_araddr;
   assign s_arlen   = w_sel ? m1_arlen  : m0_arlen;
   assign s_rready  = w_in_r & (w_sel ? m1_rready : m0_rready);

   assign w_awready = w_in_aw & s_awready;
   assign w_wready  = w_w_ok & s_wready;
   assign w_bvalid  = w_in_b & s_bvalid;
   assign w_arready = w_in_ar & s_arready;
   assign w_rvalid  = w_in_r & s_rvalid;
   // Beat count terminates the burst even if the slave never raises rlast.
   assign w_rlast   = w_in_r & (s_rlast | w_last_beat);

   assign m0_awready = w_awready & ~w_sel;
   assign m1_awready = w_awready &  w_sel;
   assign m0_wready  = w_wready  & ~w_sel;
   assign m1_wready  = w_wready  &  w_sel;
   assign m0_bvalid  = w_bvalid  & ~w_sel;
   assign m1_bvalid  = w_bvalid  &  w_sel;
   assign m0_arready = w_arready & ~w_sel;
   assign m1_arready = w_arready &  w_sel;
   assign m0_rvalid  = w_rvalid  & ~w_sel;
   assign m1_rvalid  = w_rvalid  &  w_sel;
   assign m0_rlast   = w_rlast   & ~w_sel;
   assign m1_rlast   = w_rlast   &  w_sel;
   assign m0_rdata   = s_rdata;
   assign m1_rdata   = s_rdata;

   assign w_aw_hs = s_awvalid & s_awready;
   assign w_w_hs  = s_wvalid  & s_wready;
   assign w_b_hs  = s_bvalid  & s_bready;
   assign w_ar_hs = s_arvalid & s_arready;
   assign w_r_hs  = s_rvalid  & s_rready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_grant   <= 2'b00;
         r_busy    <= 1'b0;
         r_rr_last <= 1'b1;
         r_beat    <= 9'd0;
         r_len     <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req0 | w_req1) begin
                  r_grant   <= w_win ? 2'b10 : 2'b01;
                  r_rr_last <= w_win;
                  r_busy    <= 1'b1;
                  r_state   <= w_win_aw ? S_AW : S_AR;
               end
            end
            S_AW: begin
               if (w_aw_hs) begin
                  r_len   <= s_awlen;
                  r_beat  <= 9'd0;
                  r_state <= S_W;
               end
            end
            S_W: begin
               if (w_w_hs) begin
                  r_beat <= r_beat + 9'd1;
                  if (s_wlast) r_state <= S_B;
               end
            end
            S_B: begin
               if (w_b_hs) begin
                  r_grant <= 2'b00;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_AR: begin
               if (w_ar_hs) begin
                  r_len   <= s_arlen;
                  r_beat  <= 9'd0;
                  r_state <= S_R;
               end
            end
            S_R: begin
               if (w_r_hs) begin
                  r_beat <= r_beat + 9'd1;
                  if (s_rlast | w_last_beat) begin
                     r_grant <= 2'b00;
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_grant <= 2'b00;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_grant = r_grant;
   assign o_busy  = r_busy;

endmodule

`default_nettype wire
